johnson_phase_monitor: RTL

Downstream consumer of the team's `johnson_counter`. It samples the counter's `N`-bit Johnson code and decodes it into a binary phase index and a one-hot phase vector. It checks that every sample is a legal code and a legal successor, runs a lock state machine, and counts completed rotations. It sits between the counter and any logic that needs clean phase strobes plus a health indication.

---
 rtl/johnson_pkg.sv | 10 +
 rtl/johnson_phase_monitor_decode.sv | 30 +++
 rtl/johnson_phase_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared constants for the Johnson phase monitor: FSM encodings and phase width.
package johnson_pkg;
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  function automatic int phase_w(input int n);
    return $clog2(2 * n);
  endfunction
endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson-code decode: legality, binary phase and one-hot phase.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            q,
  output logic                    legal,
  output logic [phase_w(N)-1:0]   phase,
  output logic [2*N-1:0]          onehot
);
  localparam int PW = phase_w(N);
  localparam logic [PW:0] TWO_N = (PW+1)'(2 * N);

  logic [N-1:0] x;
  logic [PW:0]  pc;
  logic [PW:0]  ph_ext;

  always_comb begin
    // Upper half of the rotation is the complement of a low-ones run.
    x     = q[N-1] ? ~q : q;
    legal = ((x & (x + 1'b1)) == '0);
    pc    = '0;
    for (int i = 0; i < N; i++) pc = pc + (PW+1)'(q[i]);
    ph_ext = q[N-1] ? (TWO_N - pc) : pc;
    phase  = ph_ext[PW-1:0];
    onehot = '0;
    if (legal) onehot[phase] = 1'b1;
  end
endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter, decodes phase, tracks lock health and counts rotations.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int RW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          q_in,
  input  logic                  clr_err,
  output logic [phase_w(N)-1:0] phase,
  output logic [2*N-1:0]        phase_onehot,
  output logic                  valid,
  output logic                  locked,
  output logic                  illegal,
  output logic                  seq_err,
  output logic                  wrap_pulse,
  output logic                  err_flag,
  output logic [RW-1:0]         rotations
);
  localparam int PW = phase_w(N);
  localparam logic [PW-1:0] LAST_PH = PW'(2 * N - 1);
  localparam logic [3:0]    LOCK_C  = 4'(LOCK_CNT);

  // Stage 1: raw sample plus a valid bit so reset flushes the pipeline.
  logic [N-1:0] q_r_q;
  logic         vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r_q <= '0;
      vld_q <= 1'b0;
    end else begin
      q_r_q <= q_in;
      vld_q <= 1'b1;
    end
  end

  logic          dec_legal;
  logic [PW-1:0] dec_ph;
  logic [2*N-1:0] dec_oh;

  johnson_decode #(.N(N)) u_dec (
    .q      (q_r_q),
    .legal  (dec_legal),
    .phase  (dec_ph),
    .onehot (dec_oh)
  );

  // Stage 2 state
  logic [PW-1:0]  phase_q, phase_d;
  logic [2*N-1:0] oh_q, oh_d;
  logic           valid_q, valid_d;
  logic           ill_q, ill_d;
  logic           seq_q, seq_d;
  logic           wrap_q, wrap_d;
  logic           err_q, err_d;
  logic [RW-1:0]  rot_q, rot_d;
  logic [1:0]     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [PW-1:0]  adv_ph;

  assign adv_ph = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;

  always_comb begin
    phase_d = phase_q;
    oh_d    = '0;
    valid_d = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    wrap_d  = 1'b0;
    rot_d   = rot_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vld_q) begin
      valid_d = dec_legal;
      oh_d    = dec_oh;
      if (!dec_legal) begin
        ill_d   = 1'b1;
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
      end else begin
        phase_d = dec_ph;
        if (state_q == ST_UNLOCKED) begin
          // No previous phase to compare against yet.
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end else if (dec_ph == phase_q) begin
          state_d = state_q;
        end else if (dec_ph == adv_ph) begin
          if (state_q == ST_ACQUIRE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == LOCK_C) state_d = ST_LOCKED;
          end else if (phase_q == LAST_PH) begin
            wrap_d = 1'b1;
            if (rot_q != {RW{1'b1}}) rot_d = rot_q + 1'b1;
          end
        end else begin
          seq_d   = 1'b1;
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end
      end
    end
    // A fresh error outranks a simultaneous clear.
    if (ill_d || seq_d) err_d = 1'b1;
    else if (clr_err)   err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      oh_q    <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      rot_q   <= '0;
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      oh_q    <= oh_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      rot_q   <= rot_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = oh_q;
  assign valid        = valid_q;
  assign locked       = (state_q == ST_LOCKED);
  assign illegal      = ill_q;
  assign seq_err      = seq_q;
  assign wrap_pulse   = wrap_q;
  assign err_flag     = err_q;
  assign rotations    = rot_q;
endmodule
